// File: rtl/pong_match_ctrl_if.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl_if
//
// Bundles the signals between the Pong match controller and its neighbours:
// the conditioned inputs (frame tick, buttons), the ball engine's wall
// collision reports, and the controller's state, score and gating outputs.
//
// Parameter:
//   SCORE_W      width of each score counter
//
// Signals:
//   frame_tick   one-cycle pulse per video frame
//   btn_fire     fire button level (already synchronised)
//   btn_pause    pause button level (already synchronised)
//   col_left     ball reached the left wall
//   col_right    ball reached the right wall
//   state        current controller state encoding
//   score_left   left player score
//   score_right  right player score
//   serve_dir    0 = launch rightward, 1 = launch leftward
//   ball_en      ball/paddle motion enable
//   ball_reset   hold ball at centre
//   win_left     left player has won
//   win_right    right player has won
//
// Modports:
//   master       the side that drives the inputs and observes the outputs
//   slave        the match controller itself
// -----------------------------------------------------------------------------
interface pong_match_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               btn_fire;
    logic               btn_pause;
    logic               col_left;
    logic               col_right;
    logic [2:0]         state;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic               serve_dir;
    logic               ball_en;
    logic               ball_reset;
    logic               win_left;
    logic               win_right;

    modport master (
        output frame_tick, btn_fire, btn_pause, col_left, col_right,
        input  state, score_left, score_right, serve_dir,
               ball_en, ball_reset, win_left, win_right
    );

    modport slave (
        input  frame_tick, btn_fire, btn_pause, col_left, col_right,
        output state, score_left, score_right, serve_dir,
               ball_en, ball_reset, win_left, win_right
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
//
// Match controller for the Pong core. Sequences a full match (new game,
// ready, timed serve, rally, point, game over), owns both score counters, the
// serve direction and the launch countdown, and gates the ball/paddle
// datapath. Button inputs are edge detected so a held button acts once.
//
// Parameters:
//   WIN_SCORE    points needed to win (1 .. 2^SCORE_W-1)
//   SCORE_W      width of each score counter
//   SERVE_DELAY  frame ticks spent in SERVE before launch (0 allowed)
//   CNT_W        countdown width
//
// Ports:
//   clk          system clock
//   sim_rst      asynchronous active-high reset
//   bus          pong_match_ctrl_if.slave: inputs frame_tick, btn_fire,
//                btn_pause, col_left, col_right; outputs state, score_left,
//                score_right, serve_dir, ball_en, ball_reset, win_left,
//                win_right
//
// Build option:
//   PONG_PAUSE_EN  when defined, a pause press in READY, SERVE or PLAY parks
//                  the match in PAUSE and a second press resumes the saved
//                  state. When undefined btn_pause is ignored and PAUSE is
//                  treated like any other illegal encoding.
// -----------------------------------------------------------------------------
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_W     = 4,
    parameter int SERVE_DELAY = 60,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            sim_rst,
    pong_match_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        NEW_GAME = 3'd0,
        READY    = 3'd1,
        SERVE    = 3'd2,
        PLAY     = 3'd3,
        POINT    = 3'd4,
        END_GAME = 3'd5,
        PAUSE    = 3'd6
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   DELAY_VAL = CNT_W'(SERVE_DELAY);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] left_q, left_d, right_q, right_d;
    logic               dir_q, dir_d;
    logic               win_l_q, win_l_d, win_r_q, win_r_d;
    logic               fire_q, fire_rise;
    logic               pause_take;

    assign fire_rise = bus.btn_fire & ~fire_q;

`ifdef PONG_PAUSE_EN
    logic   pause_q, pause_rise;
    state_t saved_q;

    assign pause_rise = bus.btn_pause & ~pause_q;
    assign pause_take = pause_rise &&
                        (state_q == READY || state_q == SERVE || state_q == PLAY);

    // Pause edge detect and the state to return to after a pause.
    always_ff @(posedge clk or posedge sim_rst) begin
        if (sim_rst) begin
            pause_q <= 1'b0;
            saved_q <= NEW_GAME;
        end else begin
            pause_q <= bus.btn_pause;
            if (pause_take)
                saved_q <= state_q;
        end
    end
`else
    logic unused_pause;
    assign unused_pause = bus.btn_pause;
    assign pause_take   = 1'b0;
`endif

    // All match state lives here; the next values come from the decode below.
    always_ff @(posedge clk or posedge sim_rst) begin
        if (sim_rst) begin
            state_q <= NEW_GAME;
            cnt_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            dir_q   <= 1'b0;
            win_l_q <= 1'b0;
            win_r_q <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
            dir_q   <= dir_d;
            win_l_q <= win_l_d;
            win_r_q <= win_r_d;
            fire_q  <= bus.btn_fire;
        end
    end

    // Next-state and datapath decode. A pause press outranks anything else
    // the current state would do this cycle, so a same-cycle collision or
    // fire is dropped. Scores are cleared on the way into NEW_GAME so the
    // new game shows 0-0 from its first cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        right_d = right_q;
        dir_d   = dir_q;
        win_l_d = win_l_q;
        win_r_d = win_r_q;

        if (pause_take) begin
            state_d = PAUSE;
        end else begin
            case (state_q)
                NEW_GAME: state_d = READY;
                READY: begin
                    if (fire_rise) begin
                        state_d = SERVE;
                        cnt_d   = DELAY_VAL;
                    end
                end
                SERVE: begin
                    // Launch is checked before the tick so a tick at zero
                    // can never wrap the countdown.
                    if (cnt_q == '0)
                        state_d = PLAY;
                    else if (bus.frame_tick)
                        cnt_d = cnt_q - CNT_W'(1);
                end
                PLAY: begin
                    if (bus.col_left && bus.col_right) begin
                        state_d = READY;
                    end else if (bus.col_left) begin
                        state_d = POINT;
                        dir_d   = 1'b1;
                        if (right_q != WIN_VAL)
                            right_d = right_q + SCORE_W'(1);
                    end else if (bus.col_right) begin
                        state_d = POINT;
                        dir_d   = 1'b0;
                        if (left_q != WIN_VAL)
                            left_d = left_q + SCORE_W'(1);
                    end
                end
                POINT: begin
                    if (left_q == WIN_VAL || right_q == WIN_VAL) begin
                        state_d = END_GAME;
                        win_l_d = (left_q == WIN_VAL);
                        win_r_d = (right_q == WIN_VAL);
                    end else begin
                        state_d = READY;
                    end
                end
                END_GAME: begin
                    if (fire_rise)
                        state_d = NEW_GAME;
                end
`ifdef PONG_PAUSE_EN
                PAUSE: begin
                    if (pause_rise)
                        state_d = saved_q;
                end
`endif
                default: state_d = NEW_GAME;
            endcase
        end

        if (state_d == NEW_GAME) begin
            cnt_d   = '0;
            left_d  = '0;
            right_d = '0;
            dir_d   = 1'b0;
            win_l_d = 1'b0;
            win_r_d = 1'b0;
        end
    end

    // Outputs are the registers themselves or a decode of the state register.
    assign bus.state       = state_q;
    assign bus.score_left  = left_q;
    assign bus.score_right = right_q;
    assign bus.serve_dir   = dir_q;
    assign bus.win_left    = win_l_q;
    assign bus.win_right   = win_r_q;
    assign bus.ball_en     = (state_q == PLAY);
    assign bus.ball_reset  = (state_q == NEW_GAME) || (state_q == READY) ||
                             (state_q == SERVE)    || (state_q == POINT) ||
                             (state_q == END_GAME);
endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Parametrised match controller for the Pong core: sequences a full match (new game, serve, rally, point, game over), owns both score counters, the serve direction and the launch countdown, and gates the ball/paddle datapath. Sits between the input conditioning (buttons, frame tick) and the ball engine, which reports wall collisions back. It generalises the fixed 4-state, win-at-5 controller with a configurable win score, a timed serve, alternating serve direction, registered winner flags and an optional pause mode.

## Interface
- WIN_SCORE, 5: points needed to win; 1 ≤ WIN_SCORE ≤ 2^SCORE_W − 1
- SCORE_W, 4: width of each score counter
- SERVE_DELAY, 60: frame_tick pulses spent in SERVE before launch; 0 allowed
- CNT_W, 8: countdown width; SERVE_DELAY ≤ 2^CNT_W − 1
- clk  in  1  system clock
- sim_rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- btn_fire  in  1  fire button level (synchronised upstream)
- btn_pause  in  1  pause button level (synchronised upstream)
- col_left  in  1  ball reached left wall (right player scores)
- col_right  in  1  ball reached right wall (left player scores)
- state  out  3  current state encoding
- score_left, score_right  out  SCORE_W  scores
- serve_dir  out  1  0 = launch rightward, 1 = launch leftward
- ball_en  out  1  ball/paddle motion enable
- ball_reset  out  1  hold ball at centre
- win_left, win_right  out  1  winner flags

## Operation
- Rising-edge detect on btn_fire and btn_pause (one registered copy each); "fire" and "pause" below mean rises. Held buttons never retrigger.
- States: NEW_GAME=0, READY=1, SERVE=2, PLAY=3, POINT=4, END_GAME=5, PAUSE=6; 7 is illegal and goes to NEW_GAME.
- NEW_GAME: clear scores, win flags, serve_dir=0; next cycle READY.
- READY: ball_reset=1; fire → SERVE, countdown loaded with SERVE_DELAY.
- SERVE: ball_reset=1; countdown decrements on frame_tick; countdown==0 → PLAY next edge.
- PLAY: ball_en=1. Exactly one collision → POINT; col_left increments score_right and sets serve_dir=1; col_right increments score_left and sets serve_dir=0 (ball goes toward the conceding player). Both collisions same cycle → READY, no score change, serve_dir unchanged.
- POINT: single cycle; either score == WIN_SCORE → END_GAME with win_left/win_right set from the score reaching WIN_SCORE; else READY.
- END_GAME: ball_reset=1, scores and win flags held; fire → NEW_GAME.
- Scores change only on the PLAY→POINT edge, never exceed WIN_SCORE.
- Outputs: ball_en=1 only in PLAY; ball_reset=1 in NEW_GAME, READY, SERVE, POINT, END_GAME; all outputs registered or decoded from registered state only.

## Timing
- Reset (async assert, sync release): state=NEW_GAME, scores=0, serve_dir=0, win_*=0, ball_en=0, ball_reset=1, countdown=0, edge-detect registers=0.
- fire in READY → state=SERVE next cycle.
- SERVE duration: SERVE_DELAY frame_ticks plus one cycle; SERVE_DELAY=0 → exactly one cycle.
- Collision in PLAY → POINT next cycle with updated score visible same edge; READY/END_GAME one cycle later.
- Reset mid-rally or mid-countdown: immediate return to reset values; no partial score update.
- frame_tick coincident with countdown==0: transition to PLAY, no underflow.

## Configuration
- PONG_PAUSE_EN defined: pause in READY, SERVE or PLAY → PAUSE, return state saved; in PAUSE ball_en=0, ball_reset=0, countdown frozen, collisions and fire ignored; pause → saved state. Pause beats a same-cycle collision or fire.
- PONG_PAUSE_EN undefined: btn_pause ignored, PAUSE unreachable (treated as illegal), no extra registers.

## Test plan
- Reset mid-PLAY with score 2–1 → state=0, scores 0–0, ball_reset=1 while sim_rst high, READY one cycle after release.
- SERVE_DELAY=3: fire in READY → SERVE; three frame_ticks → PLAY one cycle after the third; fire held high never re-enters SERVE.
- Five col_right rallies, WIN_SCORE=5 → score_left=5, win_left=1, state=END_GAME; fire → NEW_GAME then READY with 0–0.
- col_left and col_right same cycle in PLAY → READY, scores and serve_dir unchanged; col_left alone → score_right+1, serve_dir=1.
- SERVE_DELAY=0: fire → SERVE for exactly one cycle → PLAY.
- With PONG_PAUSE_EN: pause in SERVE at countdown 2, ten frame_ticks, pause → SERVE with countdown 2; pause plus col_left same cycle in PLAY → PAUSE, no score.
